// File: rtl/sargantana_icache_pkg.sv
// Shared types and helpers for the instruction-cache hit pipeline.
//   hit_res_t  : registered lookup outcome (hit flag, hitting way, multi-hit flag)
//   calc_off_w : width of the fetch-chunk index inside a line (at least 1)
//   calc_way_w : width of a way index
// No ports; imported by the interface, the top and its sub-module.
package sargantana_icache_pkg;

    // Way field sized for up to 256 ways; users slice off the bits they need.
    localparam int WAY_W_MAX = 8;

    typedef struct packed {
        logic                 hit;
        logic [WAY_W_MAX-1:0] way;
        logic                 multi_hit;
    } hit_res_t;

    function automatic int calc_off_w(input int line_w, input int fetch_w);
        int ratio;
        ratio = line_w / fetch_w;
        return (ratio <= 1) ? 1 : $clog2(ratio);
    endfunction

    function automatic int calc_way_w(input int n_way);
        return (n_way <= 1) ? 1 : $clog2(n_way);
    endfunction

endpackage

// File: rtl/sargantana_icache_hit_pipe_if.sv
// Request/response bundle of the instruction-cache hit pipeline.
//   master : fetch side - drives request, tag/data array reads, flush,
//            response ready and counter clear; observes the rest.
//   slave  : hit pipeline - returns req_ready, the registered response
//            and the hit/miss statistics counters.
interface sargantana_icache_hit_pipe_if #(
    parameter int ICACHE_N_WAY = 4,
    parameter int TAG_WIDTH    = 20,
    parameter int LINE_WIDTH   = 512,
    parameter int FETCH_WIDTH  = 128,
    parameter int CNT_WIDTH    = 32
) ();
    localparam int OFF_W = sargantana_icache_pkg::calc_off_w(LINE_WIDTH, FETCH_WIDTH);
    localparam int WAY_W = sargantana_icache_pkg::calc_way_w(ICACHE_N_WAY);

    logic                                     req_valid_i;
    logic                                     req_ready_o;
    logic [TAG_WIDTH-1:0]                     req_tag_i;
    logic [OFF_W-1:0]                         req_off_i;
    logic [ICACHE_N_WAY-1:0]                  way_valid_i;
    logic [ICACHE_N_WAY-1:0][TAG_WIDTH-1:0]   read_tags_i;
    logic [ICACHE_N_WAY-1:0][LINE_WIDTH-1:0]  data_rd_i;
    logic                                     flush_i;
    logic                                     rsp_valid_o;
    logic                                     rsp_ready_i;
    logic                                     rsp_hit_o;
    logic [WAY_W-1:0]                         rsp_way_o;
    logic                                     rsp_multi_hit_o;
    logic [FETCH_WIDTH-1:0]                   rsp_data_o;
    logic                                     cnt_clr_i;
    logic [CNT_WIDTH-1:0]                     hit_cnt_o;
    logic [CNT_WIDTH-1:0]                     miss_cnt_o;

    modport master (
        output req_valid_i, req_tag_i, req_off_i, way_valid_i, read_tags_i,
               data_rd_i, flush_i, rsp_ready_i, cnt_clr_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_multi_hit_o,
               rsp_data_o, hit_cnt_o, miss_cnt_o
    );

    modport slave (
        input  req_valid_i, req_tag_i, req_off_i, way_valid_i, read_tags_i,
               data_rd_i, flush_i, rsp_ready_i, cnt_clr_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_way_o, rsp_multi_hit_o,
               rsp_data_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/sargantana_icache_tzc_idx.sv
// Trailing-zero count: index of the lowest set bit of a vector.
//   vec   : input vector (one bit per way)
//   idx   : index of the lowest set bit, 0 when vec is all zeros
//   found : at least one bit of vec is set
module sargantana_icache_tzc_idx #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sargantana_icache_hit_pipe.sv
// Instruction-cache hit pipeline: compares the MMU tag against every way,
// picks the lowest matching way, selects one fetch chunk of its line and
// returns the result through a single registered response stage with a
// valid/ready handshake, plus saturating hit/miss statistics counters.
//   clk_i, rst_i : clock and synchronous active-high reset
//   bus (slave)  : request, tag/data array reads, flush, response,
//                  counter clear and hit/miss counts
module sargantana_icache_hit_pipe
    import sargantana_icache_pkg::*;
#(
    parameter int ICACHE_N_WAY = 4,
    parameter int TAG_WIDTH    = 20,
    parameter int LINE_WIDTH   = 512,
    parameter int FETCH_WIDTH  = 128,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    sargantana_icache_hit_pipe_if.slave  bus
);
    localparam int OFF_W   = calc_off_w(LINE_WIDTH, FETCH_WIDTH);
    localparam int WAY_W   = calc_way_w(ICACHE_N_WAY);
    localparam int N_CHUNK = LINE_WIDTH / FETCH_WIDTH;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // ---- stage p0: combinational lookup on the request cycle ----
    logic [TAG_WIDTH-1:0]                       tag_p0;
    logic [ICACHE_N_WAY-1:0]                    match_p0;
    logic [WAY_W-1:0]                           way_idx_p0;
    logic                                       found_p0;
    logic [N_CHUNK-1:0][FETCH_WIDTH-1:0]        chunks_p0;
    logic [FETCH_WIDTH-1:0]                     data_p0;
    hit_res_t                                   res_p0;
    logic                                       ready_p0;
    logic                                       accept_p0;

    assign tag_p0 = bus.req_tag_i;

    always_comb begin
        match_p0 = '0;
        for (int w = 0; w < ICACHE_N_WAY; w++) begin
            match_p0[w] = (bus.read_tags_i[w] == tag_p0) && bus.way_valid_i[w];
        end
    end

    sargantana_icache_tzc_idx #(
        .N     (ICACHE_N_WAY),
        .IDX_W (WAY_W)
    ) u_tzc (
        .vec   (match_p0),
        .idx   (way_idx_p0),
        .found (found_p0)
    );

    // The whole hitting line viewed as an array of fetch chunks.
    assign chunks_p0 = bus.data_rd_i[way_idx_p0];

    generate
        if (N_CHUNK > 1) begin : g_chunk_sel
            always_comb begin
                data_p0 = '0;
                if (found_p0) data_p0 = chunks_p0[bus.req_off_i];
            end
        end else begin : g_chunk_whole
            // Line is a single fetch chunk: the offset carries no information.
            logic unused_off;
            assign unused_off = ^bus.req_off_i;
            assign data_p0    = found_p0 ? chunks_p0[0] : '0;
        end
    endgenerate

    always_comb begin
        res_p0           = '0;
        res_p0.hit       = found_p0;
        res_p0.way       = found_p0 ? WAY_MAX_EXT(way_idx_p0) : '0;
        // Clearing the lowest set bit leaves something only if 2+ ways matched.
        res_p0.multi_hit = |(match_p0 & (match_p0 - ICACHE_N_WAY'(1)));
    end

    function automatic logic [WAY_W_MAX-1:0] WAY_MAX_EXT(input logic [WAY_W-1:0] w);
        return WAY_W_MAX'(w);
    endfunction

    // ---- stage p1: output register and statistics ----
    logic                   vld_p1;
    hit_res_t               res_p1;
    logic [FETCH_WIDTH-1:0] data_p1;
    logic [CNT_WIDTH-1:0]   hit_cnt_p1;
    logic [CNT_WIDTH-1:0]   miss_cnt_p1;

    // A held response blocks new requests; a flush blocks them outright so
    // nothing enters the register on a cycle whose contents get killed.
    assign ready_p0  = (!vld_p1 || bus.rsp_ready_i) && !bus.flush_i;
    assign accept_p0 = bus.req_valid_i && ready_p0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            res_p1  <= '0;
            data_p1 <= '0;
        end else if (bus.flush_i) begin
            vld_p1 <= 1'b0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            res_p1  <= res_p0;
            data_p1 <= data_p0;
        end else if (bus.rsp_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.cnt_clr_i) begin
            hit_cnt_p1  <= '0;
            miss_cnt_p1 <= '0;
        end else if (accept_p0) begin
            if (res_p0.hit) hit_cnt_p1  <= sat_inc(hit_cnt_p1);
            else            miss_cnt_p1 <= sat_inc(miss_cnt_p1);
        end
    end

    generate
        if (WAY_W < WAY_W_MAX) begin : g_way_pad
            // Upper way bits are always zero padding.
            logic unused_way_hi;
            assign unused_way_hi = ^res_p1.way[WAY_W_MAX-1:WAY_W];
        end
    endgenerate

    assign bus.req_ready_o     = ready_p0;
    assign bus.rsp_valid_o     = vld_p1;
    assign bus.rsp_hit_o       = res_p1.hit;
    assign bus.rsp_way_o       = res_p1.way[WAY_W-1:0];
    assign bus.rsp_multi_hit_o = res_p1.multi_hit;
    assign bus.rsp_data_o      = data_p1;
    assign bus.hit_cnt_o       = hit_cnt_p1;
    assign bus.miss_cnt_o      = miss_cnt_p1;

endmodule

// File: tb/tb_sargantana_icache_hit_pipe.sv
// Directed plus randomized bench for sargantana_icache_hit_pipe with a
// transaction-level reference model of lookup, handshake and counters.
module tb_sargantana_icache_hit_pipe;
    import sargantana_icache_pkg::*;

    localparam int NW    = 4;
    localparam int TW    = 20;
    localparam int LW    = 512;
    localparam int FW    = 128;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int OFF_W = calc_off_w(LW, FW);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sargantana_icache_hit_pipe_if #(
        .ICACHE_N_WAY(NW), .TAG_WIDTH(TW), .LINE_WIDTH(LW),
        .FETCH_WIDTH(FW), .CNT_WIDTH(CW)
    ) bus ();

    sargantana_icache_hit_pipe #(
        .ICACHE_N_WAY(NW), .TAG_WIDTH(TW), .LINE_WIDTH(LW),
        .FETCH_WIDTH(FW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of what the consumer should currently see.
    bit         m_vld, m_hit, m_multi;
    int         m_way;
    logic [FW-1:0] m_data;
    int         m_hc, m_mc;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference lookup straight from the rules: lowest matching valid way,
    // count of matches, chunk 'off' of that way's line; zeros on a miss.
    task automatic ref_lookup(output bit hit, output int way, output bit multi,
                              output logic [FW-1:0] data);
        int n;
        logic [LW-1:0] ln;
        n = 0; way = 0; data = '0;
        for (int w = 0; w < NW; w++) begin
            if (bus.way_valid_i[w] && bus.read_tags_i[w] == bus.req_tag_i) begin
                if (n == 0) way = w;
                n++;
            end
        end
        hit   = (n > 0);
        multi = (n >= 2);
        if (hit) begin
            ln   = bus.data_rd_i[way] >> (int'(bus.req_off_i) * FW);
            data = ln[FW-1:0];
        end
    endtask

    // One clock: inputs must already be driven. Checks ready before the
    // edge, advances the model, checks outputs after the edge.
    task automatic step(input bit all_fields);
        bit exp_rdy, acc, h, mh;
        int w;
        logic [FW-1:0] d;
        #1;
        exp_rdy = (!m_vld || bus.rsp_ready_i) && !bus.flush_i;
        chk("req_ready", bus.req_ready_o, exp_rdy);
        acc = bus.req_valid_i && exp_rdy;
        ref_lookup(h, w, mh, d);
        @(posedge clk);
        #1;
        if (rst) begin
            m_vld = 0; m_hit = 0; m_multi = 0; m_way = 0; m_data = '0;
            m_hc = 0; m_mc = 0;
        end else begin
            if (bus.flush_i) m_vld = 0;
            else if (acc) begin
                m_vld = 1; m_hit = h; m_way = w; m_multi = mh; m_data = d;
            end else if (bus.rsp_ready_i) m_vld = 0;
            if (bus.cnt_clr_i) begin
                m_hc = 0; m_mc = 0;
            end else if (acc) begin
                if (h) m_hc = (m_hc < CMAX) ? m_hc + 1 : CMAX;
                else   m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
            end
        end
        chk("rsp_valid", bus.rsp_valid_o, m_vld);
        chk("hit_cnt", bus.hit_cnt_o, m_hc);
        chk("miss_cnt", bus.miss_cnt_o, m_mc);
        if (m_vld || all_fields) begin
            chk("rsp_hit", bus.rsp_hit_o, m_hit);
            chk("rsp_way", bus.rsp_way_o, m_way);
            chk("rsp_multi", bus.rsp_multi_hit_o, m_multi);
            chk("rsp_data", bus.rsp_data_o, m_data);
        end
    endtask

    task automatic rand_lines();
        for (int w = 0; w < NW; w++)
            for (int c = 0; c < LW / 32; c++)
                bus.data_rd_i[w][c*32 +: 32] = $urandom();
    endtask

    // Tag array where 'mask' selects ways holding tag t; others differ from t.
    task automatic set_tags(input logic [TW-1:0] t, input logic [NW-1:0] mask);
        for (int w = 0; w < NW; w++)
            bus.read_tags_i[w] = mask[w] ? t : (t ^ TW'(w + 1) ^ TW'(20'h80000));
        bus.req_tag_i = t;
    endtask

    logic [LW-1:0]  line_tmp;
    logic [FW-1:0]  s_data;
    logic           s_hit, s_multi;
    logic [1:0]     s_way;
    int             hc_before;
    logic [TW-1:0]  pool [4];

    initial begin
        bus.req_valid_i = 0; bus.req_tag_i = '0; bus.req_off_i = '0;
        bus.way_valid_i = '0; bus.read_tags_i = '0; bus.data_rd_i = '0;
        bus.flush_i = 0; bus.rsp_ready_i = 1; bus.cnt_clr_i = 0;
        m_vld = 0; m_hit = 0; m_multi = 0; m_way = 0; m_data = '0; m_hc = 0; m_mc = 0;
        pool[0] = 20'h12345; pool[1] = 20'hABCDE; pool[2] = 20'h00F0F; pool[3] = 20'hFFFFF;

        // Reset: everything zero, then ready on the first free cycle.
        rst = 1;
        step(1);
        step(1);
        rst = 0;
        chk("ready_after_rst", bus.req_ready_o, 1'b1);

        // Single hit in way 2, chunk 3.
        rand_lines();
        set_tags(20'h12345, 4'b0100);
        bus.way_valid_i = 4'b1111; bus.req_off_i = 2'd3; bus.req_valid_i = 1;
        step(0);
        line_tmp = bus.data_rd_i[2];
        chk("w2_hit", bus.rsp_hit_o, 1'b1);
        chk("w2_way", bus.rsp_way_o, 2'd2);
        chk("w2_data", bus.rsp_data_o, line_tmp[511:384]);
        chk("w2_hit_cnt", bus.hit_cnt_o, 4'd1);

        // Two matching ways: lowest wins, multi-hit flagged.
        set_tags(20'h0BEEF, 4'b1010); bus.req_off_i = 2'd1;
        step(0);
        chk("multi_way", bus.rsp_way_o, 2'd1);
        chk("multi_flag", bus.rsp_multi_hit_o, 1'b1);

        // Matching tag in an invalid way is a miss.
        set_tags(20'h55555, 4'b0001); bus.way_valid_i = 4'b1110;
        step(0);
        chk("inv_hit", bus.rsp_hit_o, 1'b0);
        chk("inv_data", bus.rsp_data_o, '0);
        chk("inv_miss_cnt", bus.miss_cnt_o, 4'd1);

        // Drain, then accept one and stall three cycles with requests pending.
        bus.req_valid_i = 0; bus.way_valid_i = 4'b1111;
        step(0);
        set_tags(20'h33333, 4'b1000); bus.req_off_i = 2'd2; bus.req_valid_i = 1;
        step(0);
        s_data = bus.rsp_data_o; s_way = bus.rsp_way_o;
        s_hit = bus.rsp_hit_o; s_multi = bus.rsp_multi_hit_o;
        bus.rsp_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            rand_lines();
            set_tags(pool[i], 4'b0001 << i); bus.req_off_i = OFF_W'(i);
            step(0);
            chk("stall_ready", bus.req_ready_o, 1'b0);
            chk("stall_data", bus.rsp_data_o, s_data);
            chk("stall_way", bus.rsp_way_o, s_way);
            chk("stall_hit", bus.rsp_hit_o, s_hit);
            chk("stall_multi", bus.rsp_multi_hit_o, s_multi);
        end
        bus.rsp_ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_tags(pool[i], 4'b0011 << i);
            step(0);
            chk("b2b_valid", bus.rsp_valid_o, 1'b1);
        end

        // Flush with a response held and a request offered.
        hc_before = m_hc;
        bus.rsp_ready_i = 0; bus.flush_i = 1;
        set_tags(20'h77777, 4'b0100);
        step(0);
        chk("flush_valid", bus.rsp_valid_o, 1'b0);
        chk("flush_nocount", bus.hit_cnt_o, CW'(hc_before));
        bus.flush_i = 0; bus.rsp_ready_i = 1; bus.req_valid_i = 0;
        step(0);

        // Counter saturation and clear priority.
        bus.cnt_clr_i = 1;
        step(0);
        bus.cnt_clr_i = 0;
        set_tags(20'h24680, 4'b0010); bus.req_valid_i = 1;
        for (int i = 0; i < 20; i++) step(0);
        chk("sat_hit_cnt", bus.hit_cnt_o, 4'd15);
        bus.cnt_clr_i = 1;
        step(0);
        chk("clr_prio", bus.hit_cnt_o, 4'd0);
        bus.cnt_clr_i = 0;

        // Reset while a response is stalled.
        step(0);
        bus.rsp_ready_i = 0; bus.req_valid_i = 0;
        step(0);
        rst = 1;
        step(1);
        chk("rst_stall_valid", bus.rsp_valid_o, 1'b0);
        chk("rst_stall_data", bus.rsp_data_o, '0);
        rst = 0; bus.rsp_ready_i = 1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (i % 4 == 0) rand_lines();
            for (int w = 0; w < NW; w++) bus.read_tags_i[w] = pool[$urandom_range(3)];
            bus.req_tag_i   = pool[$urandom_range(3)];
            bus.way_valid_i = NW'($urandom());
            bus.req_off_i   = OFF_W'($urandom());
            bus.req_valid_i = ($urandom_range(9) < 7);
            bus.rsp_ready_i = ($urandom_range(3) != 0);
            bus.flush_i     = ($urandom_range(15) == 0);
            bus.cnt_clr_i   = ($urandom_range(31) == 0);
            step(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sargantana_icache_hit_pipe.md
SARGANTANA_ICACHE_HIT_PIPE -- requirements
Module: sargantana_icache_hit_pipe

Interface
REQ-001 Parameter ICACHE_N_WAY, default 4: number of ways; SHALL be a power of two, at least 2.
REQ-002 Parameter TAG_WIDTH, default 20: physical tag width.
REQ-003 Parameter LINE_WIDTH, default 512: cache line width in bits.
REQ-004 Parameter FETCH_WIDTH, default 128: fetch chunk width; LINE_WIDTH SHALL be an integer multiple of FETCH_WIDTH.
REQ-005 Parameter CNT_WIDTH, default 32: hit/miss counter width.
REQ-006 Derived OFF_W = max(1, clog2(LINE_WIDTH/FETCH_WIDTH)); WAY_W = clog2(ICACHE_N_WAY).
REQ-007 Port list (name, direction, width, meaning); one clock; reset is synchronous and active-high:
 clk_i  in  1  clock
 rst_i  in  1  synchronous active-high reset
 req_valid_i  in  1  lookup request valid
 req_ready_o  out  1  lookup accepted this cycle
 req_tag_i  in  TAG_WIDTH  paddr tag from MMU
 req_off_i  in  OFF_W  fetch chunk index within line
 way_valid_i  in  ICACHE_N_WAY  per-way valid bits
 read_tags_i  in  ICACHE_N_WAY x TAG_WIDTH  tags read from tag array
 data_rd_i  in  ICACHE_N_WAY x LINE_WIDTH  lines read from data array
 flush_i  in  1  kill in-flight response
 rsp_valid_o  out  1  response valid
 rsp_ready_i  in  1  consumer accepts response
 rsp_hit_o  out  1  lookup hit
 rsp_way_o  out  WAY_W  hitting way (lowest index)
 rsp_multi_hit_o  out  1  more than one way matched
 rsp_data_o  out  FETCH_WIDTH  selected fetch chunk
 cnt_clr_i  in  1  clear statistics counters
 hit_cnt_o  out  CNT_WIDTH  accepted-hit count
 miss_cnt_o  out  CNT_WIDTH  accepted-miss count

Function
REQ-008 Per-way match SHALL be (read_tags_i[w] == req_tag_i) AND way_valid_i[w].
REQ-009 Hit SHALL be the OR of matches; way SHALL be the lowest matching index (trailing-zero count); multi-hit SHALL be set when two or more ways match.
REQ-010 Chunk select SHALL take data_rd_i[way] bits [req_off_i*FETCH_WIDTH +: FETCH_WIDTH]; when LINE_WIDTH == FETCH_WIDTH the offset SHALL be ignored.
REQ-011 On a miss, rsp_data_o SHALL be zero and rsp_way_o SHALL be zero.
REQ-012 A request SHALL be accepted when req_valid_i and req_ready_o are both high.
REQ-013 req_ready_o SHALL equal (!rsp_valid_o OR rsp_ready_i) AND !flush_i.
REQ-014 An accepted request SHALL produce rsp_valid_o exactly one cycle later, with all rsp_* fields registered.
REQ-015 While rsp_valid_o is high and rsp_ready_i is low, every rsp_* output SHALL remain stable.
REQ-016 When a response is consumed and a new request is accepted in the same cycle, the output register SHALL load the new result with no bubble.
REQ-017 When flush_i is high, rsp_valid_o SHALL be 0 on the next cycle regardless of rsp_ready_i, and no request SHALL be accepted that cycle.
REQ-018 hit_cnt_o SHALL increment on each accepted hit, and miss_cnt_o on each accepted miss.
REQ-019 Both counters SHALL saturate at all-ones.
REQ-020 cnt_clr_i SHALL zero both counters and SHALL take priority over a same-cycle increment.
REQ-021 Requests accepted in a flush cycle do not exist (REQ-017), so they SHALL NOT be counted.

Reset
REQ-022 While rst_i is high at a clock edge, rsp_valid_o, rsp_hit_o, rsp_multi_hit_o, rsp_way_o, rsp_data_o, hit_cnt_o and miss_cnt_o SHALL all go to 0.
REQ-023 Reset asserted mid-stall SHALL discard the held response.
REQ-024 req_ready_o SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-025 Shared package sargantana_icache_pkg SHALL hold the hit-result struct (hit, way, multi_hit) and the OFF_W/WAY_W derivation function.
REQ-026 Lowest-way selection SHALL be a sub-module, the existing sargantana_icache_tzc_idx, instantiated once.
REQ-027 All other logic SHALL be in this module: one output register stage plus two counters.

Verification
REQ-028 Way 2 tag 0x12345 valid, off=3, LINE=512/FETCH=128 -> next cycle rsp_hit=1, way=2, data=line2[511:384], hit_cnt=1.
REQ-029 Tags match in ways 1 and 3 -> way=1, multi_hit=1.
REQ-030 Tag match but way_valid=0 -> hit=0, data=0, miss_cnt increments.
REQ-031 rsp_ready_i low for 3 cycles with req_valid_i high -> outputs stable, req_ready_o=0; on ready, back-to-back responses with no bubble.
REQ-032 flush_i with rsp_valid_o=1 -> rsp_valid_o=0 next cycle; a same-cycle request is not accepted and not counted.
REQ-033 CNT_WIDTH=4, 20 hits -> hit_cnt=15; cnt_clr_i together with a hit -> hit_cnt=0.
